// File: rtl/pipeline_stall_controller_if.sv
// Stall-controller handshake bundle: hazard/branch/SRAM requests in, per-stage freeze/flush controls out.
// Optional PIPE_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 7
);
  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             freeze_id_exe;
  logic             flush_id_exe;
  logic             freeze_exe_mem;
  logic             bubble_mem_wb;
  logic             mem_trap;
  logic [CNT_W-1:0] wait_cnt;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      stall_cycles;
  logic [15:0]      flush_events;
`endif

  modport master (
    output hazard, branch_taken, mem_req, mem_ready,
    input  freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe, flush_id_exe,
    input  freeze_exe_mem, bubble_mem_wb, mem_trap, wait_cnt
`ifdef PIPE_PERF_CNT_EN
    , input stall_cycles, flush_events
`endif
  );

  modport slave (
    input  hazard, branch_taken, mem_req, mem_ready,
    output freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe, flush_id_exe,
    output freeze_exe_mem, bubble_mem_wb, mem_trap, wait_cnt
`ifdef PIPE_PERF_CNT_EN
    , output stall_cycles, flush_events
`endif
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: zero-latency combinational controls, registered memory-wait FSM with sticky timeout trap.
// Optional PIPE_PERF_CNT_EN adds stall_cycles/flush_events counters; controls never depend on them.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_stall_controller_if.slave   bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             trap_q;
  logic             mstall;

  logic freeze_pc_c, freeze_if_id_c, flush_if_id_c, freeze_id_exe_c;
  logic flush_id_exe_c, freeze_exe_mem_c, bubble_mem_wb_c;

  assign mstall = bus.mem_req & ~bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      cnt    <= '0;
      trap_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mstall) begin
            state <= MEM_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        MEM_WAIT: begin
          // A dropped mem_req releases the wait just like mem_ready does.
          if (!mstall) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= TRAP;
            trap_q <= 1'b1;
            cnt    <= CNT_FULL;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    freeze_pc_c      = 1'b0;
    freeze_if_id_c   = 1'b0;
    flush_if_id_c    = 1'b0;
    freeze_id_exe_c  = 1'b0;
    flush_id_exe_c   = 1'b0;
    freeze_exe_mem_c = 1'b0;
    bubble_mem_wb_c  = 1'b0;
    if (rst_n) begin
      if (state == TRAP || mstall) begin
        freeze_pc_c      = 1'b1;
        freeze_if_id_c   = 1'b1;
        freeze_id_exe_c  = 1'b1;
        freeze_exe_mem_c = 1'b1;
        bubble_mem_wb_c  = 1'b1;
      end else if (bus.branch_taken) begin
        flush_if_id_c  = 1'b1;
        flush_id_exe_c = 1'b1;
      end else if (bus.hazard) begin
        freeze_pc_c    = 1'b1;
        freeze_if_id_c = 1'b1;
        flush_id_exe_c = 1'b1;
      end
    end
  end

  assign bus.freeze_pc      = freeze_pc_c;
  assign bus.freeze_if_id   = freeze_if_id_c;
  assign bus.flush_if_id    = flush_if_id_c;
  assign bus.freeze_id_exe  = freeze_id_exe_c;
  assign bus.flush_id_exe   = flush_id_exe_c;
  assign bus.freeze_exe_mem = freeze_exe_mem_c;
  assign bus.bubble_mem_wb  = bubble_mem_wb_c;
  assign bus.mem_trap       = trap_q;
  assign bus.wait_cnt       = cnt;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_events_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (freeze_pc_c)   stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_if_id_c) flush_events_q <= flush_events_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: priority/timeout model compared on every falling edge, plus literal scenario checks.
module tb_pipeline_stall_controller;
  localparam int TMO = 4;
  localparam int CW  = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

  pipeline_stall_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: consecutive memory-stall cycles seen and the sticky trap.
  int          m_waits;
  bit          m_trapped;
  logic [31:0] m_stalls;
  logic [15:0] m_flushes;

  // Control vector order: freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe,
  // flush_id_exe, freeze_exe_mem, bubble_mem_wb.
  function automatic logic [6:0] exp_ctrl(input logic rst, input bit trapped,
                                          input logic h, input logic b,
                                          input logic q, input logic r);
    if (!rst)               return 7'b0000000;
    if (trapped || (q & ~r)) return 7'b1101011;
    if (b)                  return 7'b0010100;
    if (h)                  return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {bus.freeze_pc, bus.freeze_if_id, bus.flush_if_id, bus.freeze_id_exe,
            bus.flush_id_exe, bus.freeze_exe_mem, bus.bubble_mem_wb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_waits   = 0;
      m_trapped = 1'b0;
      m_stalls  = '0;
      m_flushes = '0;
    end else begin
      logic [6:0] c;
      c = exp_ctrl(1'b1, m_trapped, bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ready);
      if (c[6]) m_stalls  = m_stalls + 32'd1;
      if (c[4]) m_flushes = m_flushes + 16'd1;
      if (!m_trapped) begin
        if (bus.mem_req & ~bus.mem_ready) begin
          m_waits++;
          if (m_waits == TMO) m_trapped = 1'b1;
        end else begin
          m_waits = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ctrl_model", {25'd0, dut_ctrl()},
          {25'd0, exp_ctrl(rst_n, m_trapped, bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ready)});
    check("wait_cnt_model", 32'(bus.wait_cnt), 32'(m_waits));
    check("mem_trap_model", 32'(bus.mem_trap), 32'(m_trapped));
`ifdef PIPE_PERF_CNT_EN
    check("stall_cycles_model", bus.stall_cycles, m_stalls);
    check("flush_events_model", 32'(bus.flush_events), 32'(m_flushes));
`endif
  end

  task automatic step(input logic h, input logic b, input logic q, input logic r);
    @(posedge clk);
    #1;
    bus.hazard       = h;
    bus.branch_taken = b;
    bus.mem_req      = q;
    bus.mem_ready    = r;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.hazard = 1'b0; bus.branch_taken = 1'b0; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    at_neg();
    check("reset_ctrl", {25'd0, dut_ctrl()}, 32'h0);
    check("reset_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    check("reset_trap", 32'(bus.mem_trap), 32'd0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Three stall cycles, then release; counter shows 1,2,3 during the wait.
    step(0, 0, 1, 0); at_neg();
    check("s2_stall_ctrl", {25'd0, dut_ctrl()}, 32'h6B);
    check("s2_cnt0", 32'(bus.wait_cnt), 32'd0);
    step(0, 0, 1, 0); at_neg();
    check("s2_cnt1", 32'(bus.wait_cnt), 32'd1);
    step(0, 0, 1, 0); at_neg();
    check("s2_cnt2", 32'(bus.wait_cnt), 32'd2);
    step(0, 0, 1, 1); at_neg();
    check("s2_cnt3_release", 32'(bus.wait_cnt), 32'd3);
    check("s2_release_ctrl", {25'd0, dut_ctrl()}, 32'h0);

    // Branch with simultaneous hazard: branch wins.
    step(1, 1, 0, 0); at_neg();
    check("s3_branch_ctrl", {25'd0, dut_ctrl()}, 32'h14);
    check("s3_cnt_cleared", 32'(bus.wait_cnt), 32'd0);
    step(0, 0, 0, 0); at_neg();
`ifdef PIPE_PERF_CNT_EN
    check("s6_stall_cycles", bus.stall_cycles, 32'd3);
    check("s6_flush_events", 32'(bus.flush_events), 32'd1);
`endif

    // Single hazard cycle.
    step(1, 0, 0, 0); at_neg();
    check("s1_hazard_ctrl", {25'd0, dut_ctrl()}, 32'h64);
    step(0, 0, 0, 0); at_neg();
    check("s1_after_ctrl", {25'd0, dut_ctrl()}, 32'h0);

    // Ready arrives on the timeout cycle with a held branch: no trap, flush.
    step(0, 1, 1, 0); at_neg();
    check("s5_stall_hides_branch", {25'd0, dut_ctrl()}, 32'h6B);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 1); at_neg();
    check("s5_cnt_at_edge", 32'(bus.wait_cnt), 32'd3);
    check("s5_release_flush", {25'd0, dut_ctrl()}, 32'h14);
    step(0, 0, 0, 0); at_neg();
    check("s5_no_trap", 32'(bus.mem_trap), 32'd0);

    // mem_req dropping mid-wait releases; hazard rule applies that cycle.
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0); at_neg();
    check("drop_req_hazard", {25'd0, dut_ctrl()}, 32'h64);
    step(0, 0, 0, 0); at_neg();
    check("drop_req_cnt", 32'(bus.wait_cnt), 32'd0);

    // Hung memory: trap after TMO stall cycles, sticky against ready.
    for (int i = 0; i < TMO; i++) step(0, 0, 1, 0);
    at_neg();
    check("s4_pre_trap", 32'(bus.mem_trap), 32'd0);
    step(0, 0, 1, 1); at_neg();
    check("s4_trap_set", 32'(bus.mem_trap), 32'd1);
    check("s4_trap_ctrl", {25'd0, dut_ctrl()}, 32'h6B);
    check("s4_cnt_saturated", 32'(bus.wait_cnt), 32'd4);
    step(1, 1, 0, 0);
    step(0, 0, 0, 1); at_neg();
    check("s4_trap_sticky", {25'd0, dut_ctrl()}, 32'h6B);

    // Reset pulse clears trap and counter; reset mid-wait too.
    step(0, 0, 0, 0);
    rst_n = 1'b0;
    at_neg();
    check("s4_reset_trap", 32'(bus.mem_trap), 32'd0);
    check("s4_reset_ctrl", {25'd0, dut_ctrl()}, 32'h0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0); at_neg();
    check("midwait_reset_cnt", 32'(bus.wait_cnt), 32'd0);

    // Mixed pattern sweep checked only by the model.
    for (int i = 0; i < 64; i++) begin
      logic [3:0] v;
      v = 4'(i * 7 + 3);
      step(v[0], v[1], v[2], v[3] | (i[2] & i[0]));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    at_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
